// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with a one-byte valid/ready output holding stage.
//   clk            : system clock, the only clock
//   rst            : synchronous active-high reset
//   rx_pin         : asynchronous serial input, idle high
//   rx_data        : last received byte, stable while rx_data_valid unless overrun
//   rx_data_valid  : rx_data holds an unconsumed byte
//   rx_data_ready  : consumer accepts the byte when valid && ready at a clock edge
//   frame_err      : one-cycle pulse, stop bit sampled low
//   overrun        : one-cycle pulse, an unconsumed byte was overwritten
module uart_byte_rx #(
    parameter int unsigned CLK_FRE   = 50,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int unsigned HALF  = CYCLE / 2;
    localparam int unsigned CNT_W = $clog2(CYCLE);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift;
    logic               sync1;
    logic               sync2;
    logic               prev;
    logic               rx_fall_c;

    // Synchroniser plus edge-detect flop; all reset low so a line held low
    // through reset must first be seen high before a start edge can occur.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= rx_pin;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rx_fall_c = prev & ~sync2;

    // Frame state machine, bit-centre sampling and output holding stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rx_fall_c) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                // Re-check the line half a bit in; a high level means a glitch.
                START: begin
                    if (cnt == CNT_W'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= sync2 ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // LSB first: each sample enters at the top and shifts down.
                DATA: begin
                    if (cnt == CNT_W'(CYCLE - 1)) begin
                        cnt     <= '0;
                        shift   <= {sync2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Decide at mid stop bit so the next start edge is caught early.
                STOP: begin
                    if (cnt == CNT_W'(CYCLE - 1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (sync2) begin
                            rx_data       <= shift;
                            rx_data_valid <= 1'b1;
                            overrun       <= rx_data_valid & ~rx_data_ready;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed and randomized frames checked against a byte-level model.
module tb_uart_byte_rx;

    localparam int CYCLE   = 434;
    localparam int HALF    = CYCLE / 2;
    // Pin fall to first cycle with valid/frame_err high: 3 detect edges + start half + 9 bits.
    localparam int LAT     = 3 + HALF + 9 * CYCLE;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       frame_err;
    logic       overrun;

    int vectors     = 0;
    int miscompares = 0;

    int cyc = 0;
    int fall_cyc = 0;

    // Monitor state
    logic [7:0] hs_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         fe_wide = 0;
    int         ov_wide = 0;
    int         valid_rise_cyc = -1;
    int         fe_rise_cyc = -1;
    logic       valid_d = 1'b0;
    logic       fe_d = 1'b0;
    logic       ov_d = 1'b0;

    uart_byte_rx #(
        .CLK_FRE  (50),
        .BAUD_RATE(115200)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_pin       (rx_pin),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle: handshakes, pulse counts, pulse widths, rise times.
    always @(negedge clk) begin
        if (rx_data_valid && rx_data_ready) hs_q.push_back(rx_data);
        if (rx_data_valid && !valid_d) valid_rise_cyc = cyc;
        if (frame_err && !fe_d) begin
            fe_cnt++;
            fe_rise_cyc = cyc;
        end
        if (frame_err && fe_d) fe_wide++;
        if (overrun && !ov_d) ov_cnt++;
        if (overrun && ov_d) ov_wide++;
        valid_d = rx_data_valid;
        fe_d    = frame_err;
        ov_d    = overrun;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 3 time units after a rising edge, well clear of both edges.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bitc);
        rx_pin   = 1'b0;
        fall_cyc = cyc;
        tick(bitc);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            tick(bitc);
        end
        rx_pin = stop;
        tick(bitc);
        rx_pin = 1'b1;
    endtask

    function automatic logic in_window(input int d);
        return (d >= LAT) && (d <= LAT + 2);
    endfunction

    initial begin
        int         fe0;
        int         ov0;
        int         bitc;
        int         exp_fe;
        logic       bad;
        logic [7:0] b;
        logic [7:0] exp_data;
        logic [7:0] exp_q[$];

        // Reset state
        rst           = 1'b1;
        rx_pin        = 1'b1;
        rx_data_ready = 1'b0;
        tick(5);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_data_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        rst = 1'b0;
        tick(20);

        // 0x55 with ready low: latency, hold, single-cycle ready pulse
        send_frame(8'h55, 1'b1, CYCLE);
        tick(20);
        check("lat55_ok", in_window(valid_rise_cyc - fall_cyc), 1'b1);
        check("data55", rx_data, 8'h55);
        check("valid55", rx_data_valid, 1'b1);
        tick(200);
        check("hold55", rx_data_valid, 1'b1);
        rx_data_ready = 1'b1;
        tick(1);
        rx_data_ready = 1'b0;
        check("clr55", rx_data_valid, 1'b0);
        check("hs55_n", hs_q.size(), 1);
        if (hs_q.size() > 0) check("hs55", hs_q.pop_front(), 8'h55);
        exp_data = 8'h55;

        // Back-to-back 0x41, 0x42 with ready tied high
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx_data_ready = 1'b1;
        send_frame(8'h41, 1'b1, CYCLE);
        send_frame(8'h42, 1'b1, CYCLE);
        tick(300);
        check("b2b_n", hs_q.size(), 2);
        if (hs_q.size() > 0) check("b2b_0", hs_q.pop_front(), 8'h41);
        if (hs_q.size() > 0) check("b2b_1", hs_q.pop_front(), 8'h42);
        check("b2b_ovr", ov_cnt - ov0, 0);
        check("b2b_ferr", fe_cnt - fe0, 0);
        exp_data = 8'h42;

        // 100-cycle start glitch, then a real frame
        fe0 = fe_cnt;
        rx_pin = 1'b0;
        tick(100);
        rx_pin = 1'b1;
        tick(1000);
        check("glitch_hs", hs_q.size(), 0);
        check("glitch_ferr", fe_cnt - fe0, 0);
        check("glitch_data", rx_data, exp_data);
        send_frame(8'hA3, 1'b1, CYCLE);
        tick(300);
        check("a3_n", hs_q.size(), 1);
        if (hs_q.size() > 0) check("a3", hs_q.pop_front(), 8'hA3);
        exp_data = 8'hA3;

        // Stop bit forced low
        fe0 = fe_cnt;
        send_frame(8'hF0, 1'b0, CYCLE);
        tick(300);
        check("fe_cnt", fe_cnt - fe0, 1);
        check("fe_width", fe_wide, 0);
        check("fe_lat_ok", in_window(fe_rise_cyc - fall_cyc), 1'b1);
        check("fe_valid", rx_data_valid, 1'b0);
        check("fe_data", rx_data, exp_data);
        check("fe_hs", hs_q.size(), 0);

        // Overrun: 0x11 then 0x22 without consuming
        ov0 = ov_cnt;
        rx_data_ready = 1'b0;
        send_frame(8'h11, 1'b1, CYCLE);
        tick(50);
        check("ov_first", ov_cnt - ov0, 0);
        check("ov_d11", rx_data, 8'h11);
        send_frame(8'h22, 1'b1, CYCLE);
        tick(50);
        check("ov_cnt", ov_cnt - ov0, 1);
        check("ov_width", ov_wide, 0);
        check("ov_data", rx_data, 8'h22);
        check("ov_valid", rx_data_valid, 1'b1);
        rx_data_ready = 1'b1;
        tick(1);
        rx_data_ready = 1'b0;
        check("ov_clr", rx_data_valid, 1'b0);
        check("ov_hs_n", hs_q.size(), 1);
        if (hs_q.size() > 0) check("ov_hs", hs_q.pop_front(), 8'h22);

        // Reset during bit 4 of 0x3C with the line held low across release
        fe0 = fe_cnt;
        b = 8'h3C;
        rx_pin = 1'b0;
        tick(CYCLE);
        for (int i = 0; i < 4; i++) begin
            rx_pin = b[i];
            tick(CYCLE);
        end
        rx_pin = 1'b0;
        tick(100);
        rst = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(1);
        check("mr_data", rx_data, 8'h00);
        check("mr_valid", rx_data_valid, 1'b0);
        check("mr_ferr", frame_err, 1'b0);
        check("mr_ovr", overrun, 1'b0);
        tick(200);
        rx_pin = 1'b1;
        tick(5000);
        check("mr_noval", rx_data_valid, 1'b0);
        check("mr_nohs", hs_q.size(), 0);
        check("mr_nofe", fe_cnt - fe0, 0);
        rx_data_ready = 1'b1;
        send_frame(8'h7E, 1'b1, CYCLE);
        tick(300);
        check("7e_n", hs_q.size(), 1);
        if (hs_q.size() > 0) check("7e", hs_q.pop_front(), 8'h7E);

        // Randomized frames within +-2 % baud error, some with a bad stop bit
        fe0    = fe_cnt;
        ov0    = ov_cnt;
        exp_fe = 0;
        for (int f = 0; f < 10; f++) begin
            b    = 8'($urandom_range(0, 255));
            bad  = ($urandom_range(0, 3) == 0);
            bitc = int'($urandom_range(426, 442));
            send_frame(b, !bad, bitc);
            if (bad) begin
                exp_fe++;
                tick(bitc);
            end else begin
                exp_q.push_back(b);
            end
        end
        tick(600);
        check("rnd_fe", fe_cnt - fe0, exp_fe);
        check("rnd_ovr", ov_cnt - ov0, 0);
        check("rnd_n", hs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && hs_q.size() > 0) begin
            check("rnd_byte", hs_q.pop_front(), exp_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
